// File: rtl/transient_sequencer_if.sv
// Handshake bundle between the beat detector / BPM measurement and the transient sequencer.
// The master side drives the beat/period inputs; the slave side returns ROM address and status.
interface transient_sequencer_if #(
    parameter int unsigned SWITCH_BITS = 4,
    parameter int unsigned BPM_BITS    = 11,
    parameter int unsigned ADDR_BITS   = 15
);
    logic                   sample_valid;
    logic                   beat;
    logic                   enable;
    logic [BPM_BITS-1:0]    bpm;
    logic [SWITCH_BITS-1:0] switch;
    logic [ADDR_BITS-1:0]   rom_addr;
    logic                   playing;
    logic                   mix_en;
    logic                   trig;
    logic [1:0]             state;

    modport master (
        output sample_valid, beat, enable, bpm, switch,
        input  rom_addr, playing, mix_en, trig, state
    );

    modport slave (
        input  sample_valid, beat, enable, bpm, switch,
        output rom_addr, playing, mix_en, trig, state
    );
endinterface

// File: rtl/transient_sequencer.sv
// Decides when a drum sample (re)starts from beat pulses or a free-running period counter,
// then steps the sample ROM address once per audio sample.
module transient_sequencer #(
    parameter int unsigned SWITCH_BITS     = 4,
    parameter int unsigned BPM_BITS        = 11,
    parameter int unsigned DECIMATION_BITS = 6,
    parameter int unsigned COUNT_BITS      = DECIMATION_BITS + BPM_BITS,
    parameter int unsigned TRANSIENT_DEPTH = 26495,
    parameter int unsigned ADDR_BITS       = $clog2(TRANSIENT_DEPTH)
) (
    input logic                  clk,
    input logic                  rst,
    transient_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArmed = 2'd1,
        StPlay  = 2'd2
    } state_e;

    localparam logic [ADDR_BITS-1:0] LastAddr = ADDR_BITS'(TRANSIENT_DEPTH - 1);

    state_e                state_q, state_d;
    logic [COUNT_BITS-1:0] count_q, count_d;
    logic [COUNT_BITS-1:0] period_q, period_d;
    logic [COUNT_BITS-1:0] period_sel;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic                  trig_q, trig_d;
    logic                  playing_q, mix_en_q;
    logic                  active, wrap, start;

    // Highest set switch bit wins: later iterations override lower bits.
    always_comb begin
        period_sel = '0;
        for (int i = 0; i < SWITCH_BITS; i++) begin
            if (bus.switch[i]) begin
                period_sel = COUNT_BITS'(bus.bpm) << (DECIMATION_BITS - i);
            end
        end
    end

    assign active = bus.enable && (bus.switch != '0);
    assign wrap   = bus.sample_valid && (period_q != '0) &&
                    (count_q == period_q - COUNT_BITS'(1));
    assign start  = bus.beat || wrap;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        period_d = period_q;
        addr_d   = addr_q;
        trig_d   = 1'b0;

        if (state_q == StIdle) begin
            period_d = period_sel;
        end

        if (!active) begin
            state_d = StIdle;
            count_d = '0;
            addr_d  = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d = StArmed;
                    count_d = '0;
                    addr_d  = '0;
                end
                StArmed, StPlay: begin
                    if (start) begin
                        state_d  = StPlay;
                        count_d  = '0;
                        addr_d   = '0;
                        trig_d   = 1'b1;
                        period_d = period_sel;
                    end else if (bus.sample_valid) begin
                        // Saturate so a zero period never wraps on its own.
                        if (count_q != '1) begin
                            count_d = count_q + COUNT_BITS'(1);
                        end
                        if (state_q == StPlay) begin
                            if (addr_q == LastAddr) begin
                                state_d = StArmed;
                                addr_d  = '0;
                            end else begin
                                addr_d = addr_q + ADDR_BITS'(1);
                            end
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    count_d = '0;
                    addr_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            count_q   <= '0;
            period_q  <= '0;
            addr_q    <= '0;
            trig_q    <= 1'b0;
            playing_q <= 1'b0;
            mix_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            period_q  <= period_d;
            addr_q    <= addr_d;
            trig_q    <= trig_d;
            playing_q <= (state_d == StPlay);
            mix_en_q  <= playing_q;
        end
    end

    assign bus.rom_addr = addr_q;
    assign bus.playing  = playing_q;
    assign bus.mix_en   = mix_en_q;
    assign bus.trig     = trig_q;
    assign bus.state    = state_q;

endmodule

// File: tb/tb_transient_sequencer.sv
// Directed bench for transient_sequencer: a vector table for short single-cycle behaviour,
// then hand-written sequences for free-run, resync, end-of-sample and collision cases.
module tb_transient_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    transient_sequencer_if #(.SWITCH_BITS(4), .BPM_BITS(11), .ADDR_BITS(15)) bus ();

    transient_sequencer #(
        .SWITCH_BITS(4),
        .BPM_BITS(11),
        .DECIMATION_BITS(6),
        .TRANSIENT_DEPTH(26495)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic        rst;
        logic        enable;
        logic        sv;
        logic        beat;
        logic [10:0] bpm;
        logic [3:0]  sw;
        logic [1:0]  st;
        logic [14:0] addr;
        logic        p;
        logic        m;
        logic        t;
    } vec_t;

    vec_t tbl [14];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One idle gap cycle, then one cycle with sample_valid high.
    task automatic sample_edge();
        tick();
        bus.sample_valid = 1'b1;
        tick();
        bus.sample_valid = 1'b0;
    endtask

    task automatic check(input string name, input logic [1:0] st, input logic [14:0] addr,
                         input logic p, input logic m, input logic t);
        vectors++;
        if (bus.state !== st || bus.rom_addr !== addr || bus.playing !== p ||
            bus.mix_en !== m || bus.trig !== t) begin
            miscompares++;
            $display("FAIL %s: got state=%0d rom_addr=%0d playing=%b mix_en=%b trig=%b, want state=%0d rom_addr=%0d playing=%b mix_en=%b trig=%b",
                     name, bus.state, bus.rom_addr, bus.playing, bus.mix_en, bus.trig,
                     st, addr, p, m, t);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    initial begin
        int trigs;
        int first;
        int bad;

        rst = 1'b1;
        bus.sample_valid = 1'b0;
        bus.beat = 1'b0;
        bus.enable = 1'b1;
        bus.bpm = '0;
        bus.switch = '0;

        //            rst   en    sv    beat  bpm     sw       st    addr   p     m     t
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 11'd0, 4'b0000, 2'd0, 15'd0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 11'd0, 4'b0000, 2'd0, 15'd0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 11'd0, 4'b0001, 2'd1, 15'd0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 11'd0, 4'b0001, 2'd1, 15'd0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 11'd0, 4'b0001, 2'd1, 15'd0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 11'd0, 4'b0001, 2'd2, 15'd0, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 11'd0, 4'b0001, 2'd2, 15'd0, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 11'd0, 4'b0001, 2'd2, 15'd1, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 11'd0, 4'b0001, 2'd2, 15'd1, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 11'd0, 4'b0001, 2'd2, 15'd0, 1'b1, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 11'd0, 4'b0001, 2'd2, 15'd0, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 4'b0001, 2'd0, 15'd0, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 11'd2, 4'b1000, 2'd0, 15'd0, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 11'd2, 4'b1000, 2'd1, 15'd0, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 14; i++) begin
            rst              = tbl[i].rst;
            bus.enable       = tbl[i].enable;
            bus.sample_valid = tbl[i].sv;
            bus.beat         = tbl[i].beat;
            bus.bpm          = tbl[i].bpm;
            bus.switch       = tbl[i].sw;
            tick();
            check($sformatf("vec%0d", i), tbl[i].st, tbl[i].addr, tbl[i].p, tbl[i].m, tbl[i].t);
        end
        bus.sample_valid = 1'b0;
        bus.beat = 1'b0;

        // Free-run with period 16: trig on every 16th sample, address ramps 0..15.
        for (int k = 1; k <= 48; k++) begin
            sample_edge();
            if (k < 16) begin
                check($sformatf("freerun k=%0d", k), 2'd1, 15'd0, 1'b0, 1'b0, 1'b0);
            end else begin
                check($sformatf("freerun k=%0d", k), 2'd2, 15'(k % 16), 1'b1, (k > 16),
                      (k % 16 == 0));
            end
        end

        // Beat resync at period 6400, with a mid-play switch change to divide-by-4.
        bus.enable = 1'b0;
        tick();
        tick();
        bus.enable = 1'b1;
        bus.bpm = 11'd100;
        bus.switch = 4'b0001;
        tick();
        check("resync armed", 2'd1, 15'd0, 1'b0, 1'b0, 1'b0);
        trigs = 0;
        for (int k = 1; k <= 37; k++) begin
            sample_edge();
            if (bus.trig) trigs++;
        end
        check_int("resync pre-beat trigs", trigs, 0);
        bus.beat = 1'b1;
        tick();
        bus.beat = 1'b0;
        check("resync beat", 2'd2, 15'd0, 1'b1, 1'b0, 1'b1);
        first = -1;
        for (int n = 1; n <= 7000; n++) begin
            if (n == 100) bus.switch = 4'b0100;
            sample_edge();
            if (bus.trig) begin
                first = n;
                break;
            end
        end
        check_int("resync free-run distance", first, 6400);
        check("resync wrap start", 2'd2, 15'd0, 1'b1, 1'b1, 1'b1);
        first = -1;
        for (int n = 1; n <= 2000; n++) begin
            sample_edge();
            if (bus.trig) begin
                first = n;
                break;
            end
        end
        check_int("new period after switch change", first, 1600);

        // End of sample: period 65472 is longer than the ROM, so only the beat starts play.
        bus.enable = 1'b0;
        tick();
        tick();
        bus.enable = 1'b1;
        bus.bpm = 11'd1023;
        bus.switch = 4'b0001;
        tick();
        bus.beat = 1'b1;
        tick();
        bus.beat = 1'b0;
        check("eos start", 2'd2, 15'd0, 1'b1, 1'b0, 1'b1);
        bad = -1;
        for (int k = 1; k <= 26494; k++) begin
            sample_edge();
            if (bad < 0 && (bus.rom_addr !== 15'(k) || bus.playing !== 1'b1 ||
                            bus.trig !== 1'b0)) begin
                bad = k;
            end
        end
        check_int("eos ramp first bad sample", bad, -1);
        check("eos last addr", 2'd2, 15'd26494, 1'b1, 1'b1, 1'b0);
        sample_edge();
        check("eos end", 2'd1, 15'd0, 1'b0, 1'b1, 1'b0);
        tick();
        check("eos mix_en drop", 2'd1, 15'd0, 1'b0, 1'b0, 1'b0);

        // Beat landing on the same sample as a wrap: one start, count restarts from 0.
        bus.enable = 1'b0;
        tick();
        tick();
        bus.enable = 1'b1;
        bus.bpm = 11'd2;
        bus.switch = 4'b1000;
        tick();
        trigs = 0;
        for (int k = 1; k <= 15; k++) begin
            sample_edge();
            if (bus.trig) trigs++;
        end
        check_int("collide pre-wrap trigs", trigs, 0);
        tick();
        bus.sample_valid = 1'b1;
        bus.beat = 1'b1;
        tick();
        bus.sample_valid = 1'b0;
        bus.beat = 1'b0;
        check("collide start", 2'd2, 15'd0, 1'b1, 1'b0, 1'b1);
        tick();
        check("collide single trig", 2'd2, 15'd0, 1'b1, 1'b1, 1'b0);
        trigs = 0;
        for (int k = 1; k <= 15; k++) begin
            sample_edge();
            if (bus.trig) trigs++;
        end
        check_int("collide post trigs", trigs, 0);
        check("collide addr 15", 2'd2, 15'd15, 1'b1, 1'b1, 1'b0);
        sample_edge();
        check("collide next wrap", 2'd2, 15'd0, 1'b1, 1'b1, 1'b1);

        rst = 1'b1;
        tick();
        check("mid-play reset", 2'd0, 15'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
